kiwi_run_controller: RTL and testbench

// Synthesisable run sequencer for one Kiwi-generated DUT on an accelerator card.

---
 rtl/kiwi_run_pkg.sv | 27 ++
 rtl/kiwi_tick_counter.sv | 31 +++
 rtl/kiwi_run_controller.sv | 163 ++++++++++++++++
 tb/tb_kiwi_run_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kiwi_run_pkg.sv
// Shared types and constants for the Kiwi run sequencer.
package kiwi_run_pkg;

  // Default result field widths.
  localparam int unsigned SYND_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 32;

  // Syndrome values that never count as a finish code.
  localparam logic [SYND_W_DEF-1:0] SYND_NONE    = '0;
  localparam logic [SYND_W_DEF-1:0] SYND_RUNNING = '1;

  typedef enum logic [2:0] {
    IDLE,
    RESET_DUT,
    RUN,
    SETTLE,
    DONE
  } run_state_t;

  // Phase-timer width: it must hold the larger of the two phase loads.
  function automatic int unsigned tick_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/kiwi_tick_counter.sv
// Loadable down counter; tc flags the last enabled clock of a phase.
module kiwi_tick_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Count register: load wins over decrement, stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Terminal count: this enabled clock is the final one of the phase.
  always_comb begin
    tc = en && (count == W'(1));
  end

endmodule

// File: rtl/kiwi_run_controller.sv
// Run sequencer for one Kiwi-generated DUT: reset, run, watch syndrome, report.
module kiwi_run_controller
  import kiwi_run_pkg::*;
#(
  parameter int unsigned SYND_W         = SYND_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              done_ack,
  input  logic [SYND_W-1:0] dut_syndrome,
  output logic              dut_reset,
  output logic              busy,
  output logic              done,
  output logic [SYND_W-1:0] result_code,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned TICK_W = tick_w(RESET_CYCLES, SETTLE_CYCLES);
  localparam logic [TICK_W-1:0] RESET_LOAD  = TICK_W'(RESET_CYCLES);
  // The RUN clock that first sees the finish code is the first settle clock,
  // so SETTLE itself only lasts SETTLE_CYCLES-1 clocks.
  localparam logic [TICK_W-1:0] SETTLE_LOAD = TICK_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WDOG_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t        state, state_next;
  logic [SYND_W-1:0] syn_q;
  logic              finish;
  logic              tick_load, tick_en, tick_tc;
  logic [TICK_W-1:0] tick_val;
  logic              run_clear, count_en, capture, capture_to, abort_clr;

  // Shared phase timer for RESET_DUT and SETTLE.
  kiwi_tick_counter #(.W(TICK_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (tick_load),
    .en       (tick_en),
    .load_val (tick_val),
    .tc       (tick_tc)
  );

  // Finish qualifier: registered syndrome that is neither SYND_NONE nor SYND_RUNNING.
  always_comb begin
    finish = (syn_q != '0) && (syn_q != '1);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath controls; abort outranks everything outside IDLE.
  always_comb begin
    state_next = state;
    tick_load  = 1'b0;
    tick_val   = RESET_LOAD;
    tick_en    = 1'b0;
    run_clear  = 1'b0;
    count_en   = 1'b0;
    capture    = 1'b0;
    capture_to = 1'b0;
    abort_clr  = 1'b0;
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      abort_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = RESET_DUT;
            tick_load  = 1'b1;
            tick_val   = RESET_LOAD;
            run_clear  = 1'b1;
          end
        end
        RESET_DUT: begin
          tick_en = 1'b1;
          if (tick_tc) begin
            state_next = RUN;
          end
        end
        RUN: begin
          count_en = 1'b1;
          if (finish) begin
            if (SETTLE_CYCLES == 1) begin
              state_next = DONE;
              capture    = 1'b1;
            end else begin
              state_next = SETTLE;
              tick_load  = 1'b1;
              tick_val   = SETTLE_LOAD;
            end
          end else if (cycle_count == WDOG_LAST) begin
            state_next = DONE;
            capture    = 1'b1;
            capture_to = 1'b1;
          end
        end
        SETTLE: begin
          count_en = 1'b1;
          tick_en  = 1'b1;
          if (tick_tc) begin
            state_next = DONE;
            capture    = 1'b1;
          end
        end
        DONE: begin
          if (done_ack) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Syndrome pipeline, elapsed counter and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syn_q       <= '0;
      cycle_count <= '0;
      result_code <= '0;
      timed_out   <= 1'b0;
    end else begin
      syn_q <= dut_syndrome;
      if (abort_clr) begin
        result_code <= '0;
        timed_out   <= 1'b0;
      end else begin
        if (run_clear) begin
          cycle_count <= '0;
          timed_out   <= 1'b0;
        end
        if (count_en) begin
          cycle_count <= cycle_count + 1'b1;
        end
        if (capture) begin
          result_code <= syn_q;
          timed_out   <= capture_to;
        end
      end
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    dut_reset = (state == IDLE) || (state == RESET_DUT);
    busy      = (state == RESET_DUT) || (state == RUN) || (state == SETTLE);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_kiwi_run_controller.sv
// Self-checking bench for kiwi_run_controller.
module tb_kiwi_run_controller;

  localparam int SW    = 8;
  localparam int CW    = 32;
  localparam int RC    = 4;
  localparam int SC    = 8;
  localparam int TC    = 50;
  localparam int SEQ_N = 80;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          done_ack;
  logic [SW-1:0] dut_syndrome;
  logic          dut_reset;
  logic          busy;
  logic          done;
  logic [SW-1:0] result_code;
  logic          timed_out;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  kiwi_run_controller #(
    .SYND_W         (SW),
    .CNT_W          (CW),
    .RESET_CYCLES   (RC),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .done_ack     (done_ack),
    .dut_syndrome (dut_syndrome),
    .dut_reset    (dut_reset),
    .busy         (busy),
    .done         (done),
    .result_code  (result_code),
    .timed_out    (timed_out),
    .cycle_count  (cycle_count)
  );

  int tests = 0;
  int fails = 0;

  // Syndrome driven during each RUN clock, indexed by clocks since dut_reset fell.
  logic [SW-1:0] seq [SEQ_N];

  typedef struct {
    string         name;
    int            fin_pos;
    logic [SW-1:0] base;
    logic [SW-1:0] code;
    logic [SW-1:0] after;
    int            exp_cnt;
    logic [SW-1:0] exp_res;
    logic          exp_to;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void fill_seq(input int fin_pos, input logic [SW-1:0] base,
                                   input logic [SW-1:0] code, input logic [SW-1:0] after);
    for (int i = 0; i < SEQ_N; i++) begin
      if (fin_pos < 0 || i < fin_pos) seq[i] = base;
      else if (i == fin_pos)          seq[i] = code;
      else                            seq[i] = after;
    end
  endfunction

  // Reference: a code driven in RUN clock i is seen one clock later; a code seen
  // in RUN clock j (j < TC) ends the run SC clocks after j, reporting whatever
  // was registered in the last clock. Otherwise the watchdog ends it at TC.
  function automatic void model(output int exp_cnt, output logic [SW-1:0] exp_res,
                                output logic exp_to);
    int j_fin;
    j_fin = -1;
    for (int j = 1; j < TC; j++) begin
      if (j_fin < 0 && seq[j-1] != 8'h00 && seq[j-1] != 8'hFF) j_fin = j;
    end
    if (j_fin < 0) begin
      exp_cnt = TC;
      exp_res = seq[TC-2];
      exp_to  = 1'b1;
    end else begin
      exp_cnt = j_fin + SC;
      exp_res = seq[j_fin + SC - 2];
      exp_to  = 1'b0;
    end
  endfunction

  // Start pulse, then measure how long dut_reset stays high after busy rises.
  task automatic begin_run(input string tag);
    int lat;
    dut_syndrome = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    lat = 0;
    while (dut_reset === 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_rst_lat"}, 32'(lat), RC);
    dut_syndrome = seq[0];
  endtask

  task automatic run_to_done(input bit noise, output int e);
    e = 0;
    while (done !== 1'b1 && e < SEQ_N - 1) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        done_ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      e++;
      dut_syndrome = seq[e];
    end
    start    = 1'b0;
    done_ack = 1'b0;
  endtask

  task automatic finish_run(input string tag, input bit noise, input int exp_cnt,
                            input logic [SW-1:0] exp_res, input logic exp_to);
    int e;
    run_to_done(noise, e);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_done_clk"}, 32'(e), 32'(exp_cnt));
    check({tag, "_count"}, cycle_count, 32'(exp_cnt));
    check({tag, "_result"}, 32'(result_code), 32'(exp_res));
    check({tag, "_timed_out"}, 32'(timed_out), 32'(exp_to));
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_hold"}, {29'd0, done, busy, dut_reset}, 32'b100);
    check({tag, "_frozen"}, cycle_count, 32'(exp_cnt));
    done_ack = 1'b1;
    @(posedge clk); #1;
    done_ack = 1'b0;
    check({tag, "_ack"}, {29'd0, done, busy, dut_reset}, 32'b001);
    dut_syndrome = 8'hFF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int            e;
    int            m_cnt;
    logic [SW-1:0] m_res;
    logic          m_to;
    logic [SW-1:0] base;
    bit            quiet;

    vt[0] = '{"hold01",      10, 8'hFF, 8'h01, 8'h01, 19, 8'h01, 1'b0};
    vt[1] = '{"wdog",        -1, 8'hFF, 8'h00, 8'h00, 50, 8'hFF, 1'b1};
    vt[2] = '{"blip05",      10, 8'hFF, 8'h05, 8'h00, 19, 8'h00, 1'b0};
    vt[3] = '{"last_chance", 48, 8'hFF, 8'h33, 8'h33, 57, 8'h33, 1'b0};
    vt[4] = '{"too_late",    49, 8'hFF, 8'h33, 8'h33, 50, 8'hFF, 1'b1};
    vt[5] = '{"idle_zero",   -1, 8'h00, 8'h00, 8'h00, 50, 8'h00, 1'b1};
    vt[6] = '{"first_clk",    0, 8'hFF, 8'h80, 8'h80,  9, 8'h80, 1'b0};
    vt[7] = '{"blip_ff",     20, 8'hFF, 8'h7E, 8'hFF, 29, 8'hFF, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; done_ack = 1'b0; dut_syndrome = 8'hFF;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_ctrl", {29'd0, done, busy, dut_reset}, 32'b001);
    check("idle_result", 32'(result_code), 0);
    check("idle_timed_out", 32'(timed_out), 0);
    check("idle_count", cycle_count, 0);

    for (int i = 0; i < 8; i++) begin
      fill_seq(vt[i].fin_pos, vt[i].base, vt[i].code, vt[i].after);
      begin_run(vt[i].name);
      finish_run(vt[i].name, 1'b0, vt[i].exp_cnt, vt[i].exp_res, vt[i].exp_to);
    end

    // Abort in SETTLE: back to IDLE, result cleared, count held.
    fill_seq(10, 8'hFF, 8'h01, 8'h01);
    begin_run("abort");
    e = 0;
    while (e < 14) begin
      @(posedge clk); #1;
      e++;
      dut_syndrome = seq[e];
    end
    check("abort_pre_busy", 32'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ctrl", {29'd0, done, busy, dut_reset}, 32'b001);
    check("abort_result", 32'(result_code), 0);
    check("abort_timed_out", 32'(timed_out), 0);
    check("abort_count", cycle_count, 14);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_stays_idle", {29'd0, done, busy, dut_reset}, 32'b001);
    dut_syndrome = 8'hFF;

    // start together with done_ack: ack taken, start dropped.
    fill_seq(0, 8'hFF, 8'h80, 8'h80);
    begin_run("ackstart");
    run_to_done(1'b0, e);
    check("ackstart_done_clk", 32'(e), 9);
    check("ackstart_result", 32'(result_code), 32'h80);
    start = 1'b1; done_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; done_ack = 1'b0;
    check("ackstart_ctrl", {29'd0, done, busy, dut_reset}, 32'b001);
    repeat (3) begin @(posedge clk); #1; end
    check("ackstart_no_run", {29'd0, done, busy, dut_reset}, 32'b001);

    // Abort in IDLE changes nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_ctrl", {29'd0, done, busy, dut_reset}, 32'b001);
    check("idle_abort_result", 32'(result_code), 32'h80);
    check("idle_abort_count", cycle_count, 9);

    // Randomised runs with stray start/done_ack noise during the run.
    for (int r = 0; r < 20; r++) begin
      base  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF;
      quiet = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < SEQ_N; i++) begin
        if (!quiet && $urandom_range(0, 99) < 4) seq[i] = 8'($urandom);
        else                                     seq[i] = base;
      end
      model(m_cnt, m_res, m_to);
      begin_run($sformatf("rnd%0d", r));
      finish_run($sformatf("rnd%0d", r), 1'b1, m_cnt, m_res, m_to);
    end

    // Asynchronous reset mid-RUN takes effect without a clock edge.
    fill_seq(-1, 8'hFF, 8'hFF, 8'hFF);
    begin_run("areset");
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_ctrl", {29'd0, done, busy, dut_reset}, 32'b001);
    check("areset_count", cycle_count, 0);
    check("areset_result", 32'(result_code), 0);
    check("areset_timed_out", 32'(timed_out), 0);
    #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("areset_after", {29'd0, done, busy, dut_reset}, 32'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
